pipeline_hazard_ctrl: RTL and testbench

//  Hazard sequencer for the 5-stage integer pipeline, beside the EX-stage forwarding unit.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_perf_cnt.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// The HAZ_PERF_CNT_EN macro (see pipeline_hazard_ctrl) does not affect this package.
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_e;

  // x0 is hardwired to zero, so a load targeting it can never create a real dependency.
  function automatic logic load_use_hit(
    input logic              mem_read,
    input logic [REG_AW-1:0] ex_rd,
    input logic [REG_AW-1:0] rs1,
    input logic [REG_AW-1:0] rs2,
    input logic              use_rs1,
    input logic              use_rs2
  );
    logic w_rs1_hit;
    logic w_rs2_hit;
    w_rs1_hit = use_rs1 && (rs1 == ex_rd);
    w_rs2_hit = use_rs2 && (rs2 == ex_rd);
    return mem_read && (ex_rd != '0) && (w_rs1_hit || w_rs2_hit);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running wrap-around event counter used for hazard performance statistics.
// Only instantiated when HAZ_PERF_CNT_EN is defined.
module hazard_perf_cnt
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer: load-use stalls, taken-branch squash and mul/div start/done handshake with watchdog.
// Define HAZ_PERF_CNT_EN to build the stall/flush performance counters; otherwise perf ports read 0.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_md_valid,
  input  logic              i_ex_branch_taken,
  input  logic              i_md_done,
  output logic              o_md_start,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_stall_ex,
  output logic              o_flush_if_id,
  output logic              o_bubble_ex,
  output logic              o_bubble_mem,
  output logic              o_md_timeout,
  output logic [CNT_W-1:0]  o_perf_stall_cnt,
  output logic [CNT_W-1:0]  o_perf_flush_cnt
);

  localparam int              WD_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

  hz_state_e       r_state;
  hz_state_e       w_state_nxt;
  logic [WD_W-1:0] r_wdog;
  logic [WD_W-1:0] w_wdog_nxt;
  logic            r_md_timeout;
  logic            w_timeout_hit;
  logic            w_load_use;

  assign w_load_use = load_use_hit(i_ex_mem_read, i_ex_rd, i_id_rs1, i_id_rs2,
                                   i_id_use_rs1, i_id_use_rs2);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= RUN;
      r_wdog       <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wdog  <= w_wdog_nxt;
      if (w_timeout_hit) begin
        r_md_timeout <= 1'b1;
      end
    end
  end

  // md_start is gated by reset so a held mul/div in EX is never launched while the block is in reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_wdog_nxt    = r_wdog;
    w_timeout_hit = 1'b0;
    o_md_start    = 1'b0;
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_stall_ex    = 1'b0;
    o_flush_if_id = 1'b0;
    o_bubble_ex   = 1'b0;
    o_bubble_mem  = 1'b0;

    case (r_state)
      RUN: begin
        if (i_ex_md_valid) begin
          o_md_start   = i_rst_n;
          o_stall_if   = 1'b1;
          o_stall_id   = 1'b1;
          o_stall_ex   = 1'b1;
          o_bubble_mem = 1'b1;
          w_state_nxt  = MD_WAIT;
          w_wdog_nxt   = '0;
        end else if (i_ex_branch_taken) begin
          o_flush_if_id = 1'b1;
          o_bubble_ex   = 1'b1;
        end else if (w_load_use) begin
          o_stall_if  = 1'b1;
          o_stall_id  = 1'b1;
          o_bubble_ex = 1'b1;
        end
      end

      MD_WAIT: begin
        if (i_md_done) begin
          w_state_nxt = RUN;
        end else if (r_wdog == WD_LAST) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = RUN;
        end else begin
          o_stall_if   = 1'b1;
          o_stall_id   = 1'b1;
          o_stall_ex   = 1'b1;
          o_bubble_mem = 1'b1;
          w_wdog_nxt   = r_wdog + WD_W'(1);
        end
      end

      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  assign o_md_timeout = r_md_timeout;

`ifdef HAZ_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (o_stall_if),
    .o_count (o_perf_stall_cnt)
  );

  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (o_flush_if_id),
    .o_count (o_perf_flush_cnt)
  );
`else
  assign o_perf_stall_cnt = '0;
  assign o_perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vectors plus a cycle-level reference model.
// Perf-counter expectations follow HAZ_PERF_CNT_EN the same way as the design.
module tb_pipeline_hazard_ctrl;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 32;

  logic             clk = 1'b0;
  logic             rstN;
  logic [4:0]       idRs1, idRs2, exRd;
  logic             useRs1, useRs2, exMemRead, exMdValid, branch, mdDone;
  logic             mdStart, stallIf, stallId, stallEx, flushIfId, bubbleEx, bubbleMem, mdTimeout;
  logic [CNT_W-1:0] perfStall, perfFlush;
  logic [6:0]       ctl;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  bit mBusy     = 1'b0;
  int mElapsed  = 0;
  bit mFlag     = 1'b0;
  int mStallCnt = 0;
  int mFlushCnt = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_id_rs1          (idRs1),
    .i_id_rs2          (idRs2),
    .i_id_use_rs1      (useRs1),
    .i_id_use_rs2      (useRs2),
    .i_ex_mem_read     (exMemRead),
    .i_ex_rd           (exRd),
    .i_ex_md_valid     (exMdValid),
    .i_ex_branch_taken (branch),
    .i_md_done         (mdDone),
    .o_md_start        (mdStart),
    .o_stall_if        (stallIf),
    .o_stall_id        (stallId),
    .o_stall_ex        (stallEx),
    .o_flush_if_id     (flushIfId),
    .o_bubble_ex       (bubbleEx),
    .o_bubble_mem      (bubbleMem),
    .o_md_timeout      (mdTimeout),
    .o_perf_stall_cnt  (perfStall),
    .o_perf_flush_cnt  (perfFlush)
  );

  // Control vector order: md_start, stall_if, stall_id, stall_ex, flush_if_id, bubble_ex, bubble_mem.
  assign ctl = {mdStart, stallIf, stallId, stallEx, flushIfId, bubbleEx, bubbleMem};

  // Reference model: outputs from "is a mul/div outstanding and for how long", then advance it.
  logic [6:0]       eCtl;
  logic [CNT_W-1:0] eStall, eFlush;
  bit               mLuse, mExpire;

  always @(negedge clk) begin
    if (checkEn) begin
      mLuse = exMemRead && (exRd != 5'd0) &&
              ((useRs1 && idRs1 == exRd) || (useRs2 && idRs2 == exRd));
      mExpire = mBusy && (mElapsed == MD_TIMEOUT - 1);
      eCtl = 7'b0;
      if (!mBusy) begin
        if (exMdValid)   eCtl = {rstN, 6'b111001};
        else if (branch) eCtl = 7'b0000110;
        else if (mLuse)  eCtl = 7'b0110010;
      end else if (!mdDone && !mExpire) begin
        eCtl = 7'b0111001;
      end
`ifdef HAZ_PERF_CNT_EN
      eStall = CNT_W'(mStallCnt);
      eFlush = CNT_W'(mFlushCnt);
`else
      eStall = '0;
      eFlush = '0;
`endif
      checks++;
      if (ctl !== eCtl) begin
        failures++;
        $display("[TB] FAIL model_ctl t=%0t got=%b want=%b", $time, ctl, eCtl);
      end
      checks++;
      if (mdTimeout !== mFlag) begin
        failures++;
        $display("[TB] FAIL model_timeout t=%0t got=%b want=%b", $time, mdTimeout, mFlag);
      end
      checks++;
      if (perfStall !== eStall || perfFlush !== eFlush) begin
        failures++;
        $display("[TB] FAIL model_perf t=%0t got=%0d/%0d want=%0d/%0d",
                 $time, perfStall, perfFlush, eStall, eFlush);
      end

      if (!rstN) begin
        mBusy = 1'b0; mElapsed = 0; mFlag = 1'b0; mStallCnt = 0; mFlushCnt = 0;
      end else begin
        if (eCtl[5]) mStallCnt++;
        if (eCtl[2]) mFlushCnt++;
        if (!mBusy) begin
          if (exMdValid) begin
            mBusy = 1'b1;
            mElapsed = 0;
          end
        end else if (mdDone) begin
          mBusy = 1'b0;
        end else if (mExpire) begin
          mBusy = 1'b0;
          mFlag = 1'b1;
        end else begin
          mElapsed++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic memRd, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic md,
                               input logic br, input logic done);
    @(posedge clk);
    #1;
    rstN = rst; exMemRead = memRd; exRd = rd; idRs1 = rs1; idRs2 = rs2;
    useRs1 = u1; useRs2 = u2; exMdValid = md; branch = br; mdDone = done;
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expCtl, input logic expTo);
    @(negedge clk);
    checks++;
    if (ctl !== expCtl) begin
      failures++;
      $display("[TB] FAIL %s ctl got=%b want=%b", name, ctl, expCtl);
    end
    checks++;
    if (mdTimeout !== expTo) begin
      failures++;
      $display("[TB] FAIL %s md_timeout got=%b want=%b", name, mdTimeout, expTo);
    end
  endtask

  task automatic checkPerf(input string name, input int expStall, input int expFlush);
    @(negedge clk);
    checks++;
    if (perfStall !== CNT_W'(expStall) || perfFlush !== CNT_W'(expFlush)) begin
      failures++;
      $display("[TB] FAIL %s perf got=%0d/%0d want=%0d/%0d", name, perfStall, perfFlush,
               expStall, expFlush);
    end
  endtask

  task automatic startMd(input logic done);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, done);
  endtask

  initial begin
    rstN = 1'b0; exMemRead = 1'b0; exRd = 5'd0; idRs1 = 5'd0; idRs2 = 5'd0;
    useRs1 = 1'b0; useRs2 = 1'b0; exMdValid = 1'b0; branch = 1'b0; mdDone = 1'b0;

    idle(1'b0);
    checkEn = 1'b1;
    checkOutput("reset_state", 7'b0000000, 1'b0);
    idle(1'b1);
    checkOutput("run_idle", 7'b0000000, 1'b0);

    // lw x5 in EX, add x6,x5,x1 in ID.
    applyStimulus(1'b1, 1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("load_use_rs1", 7'b0110010, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd6, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("load_use_release", 7'b0000000, 1'b0);

    // Taken branch with a concurrent load-use: squash wins, no stall.
    applyStimulus(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("branch_over_load_use", 7'b0000110, 1'b0);
    idle(1'b1);
    checkOutput("branch_release", 7'b0000000, 1'b0);
`ifdef HAZ_PERF_CNT_EN
    checkPerf("perf_after_1_3", 1, 1);
`else
    checkPerf("perf_after_1_3", 0, 0);
`endif

    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("load_x0", 7'b0000000, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rs2_unused", 7'b0000000, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("load_use_rs2", 7'b0110010, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("non_load_match", 7'b0000000, 1'b0);

    // mul/div completing after five wait cycles; hazards injected while waiting are ignored.
    startMd(1'b0);
    checkOutput("md_start", 7'b1111001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2)
        applyStimulus(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else if (i == 3)
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      else
        startMd(1'b0);
      checkOutput("md_wait", 7'b0111001, 1'b0);
    end
    startMd(1'b1);
    checkOutput("md_done_release", 7'b0000000, 1'b0);
    idle(1'b1);
    checkOutput("md_after_done", 7'b0000000, 1'b0);

    // md_done on the last watchdog cycle: done wins, no error.
    startMd(1'b0);
    checkOutput("md_start_edge", 7'b1111001, 1'b0);
    for (int i = 0; i < MD_TIMEOUT - 1; i++) begin
      startMd(1'b0);
      checkOutput("md_wait_edge", 7'b0111001, 1'b0);
    end
    startMd(1'b1);
    checkOutput("done_at_limit", 7'b0000000, 1'b0);
    idle(1'b1);
    checkOutput("no_timeout_flag", 7'b0000000, 1'b0);

    // Watchdog expiry: 8 stalled cycles then release and a sticky flag.
    startMd(1'b0);
    checkOutput("md_start_to", 7'b1111001, 1'b0);
    for (int i = 0; i < MD_TIMEOUT - 1; i++) begin
      startMd(1'b0);
      checkOutput("md_wait_to", 7'b0111001, 1'b0);
    end
    startMd(1'b0);
    checkOutput("timeout_release", 7'b0000000, 1'b0);
    idle(1'b1);
    checkOutput("timeout_flag_set", 7'b0000000, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("timeout_sticky_load_use", 7'b0110010, 1'b1);
    idle(1'b0);
    checkOutput("timeout_in_reset", 7'b0000000, 1'b1);
    idle(1'b1);
    checkOutput("timeout_cleared", 7'b0000000, 1'b0);

    // Reset while waiting on mul/div: back to RUN, no relaunch during reset.
    startMd(1'b0);
    checkOutput("md_start_rst", 7'b1111001, 1'b0);
    startMd(1'b0);
    checkOutput("md_wait_rst", 7'b0111001, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_in_wait", 7'b0111001, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_no_relaunch", 7'b0111001, 1'b0);
    idle(1'b1);
    checkOutput("run_after_reset", 7'b0000000, 1'b0);
    idle(1'b1);
    @(negedge clk);
    checkEn = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout sim did not finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
